// File: rtl/imm_extend_pipe.sv
// Sign/zero-extends an RV immediate selected by ImmSrc; one cycle from input transfer to out_valid.
// Backpressure: 2-entry skid buffer, in_ready comes straight from the skid valid flop (no out_ready path).
module imm_extend_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr_imm,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmOp,
  input  logic            illegal_clr,
  output logic            illegal_src
);

  // Re-index so field selects read like the instruction encoding.
  logic [31:7]     ins;
  logic [XLEN-1:0] ext;
  logic            out_vld;
  logic            skid_vld;
  logic [XLEN-1:0] out_dat;
  logic [XLEN-1:0] skid_dat;
  logic            in_xfer;
  logic            out_xfer;

  assign ins = instr_imm;

  always_comb begin
    ext = '0;
    case (ImmSrc)
      3'b000:  ext = XLEN'($signed(ins[31:20]));
      3'b001:  ext = XLEN'($signed({ins[31:25], ins[11:7]}));
      3'b010:  ext = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'b011:  ext = XLEN'($signed(ins[31:12]));
      3'b100:  ext = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'b101:  ext = XLEN'($signed({ins[31:12], 12'b0}));
      3'b110:  ext = XLEN'(ins[19:15]);
      default: ext = '0;
    endcase
  end

  assign in_ready  = ~skid_vld;
  assign out_valid = out_vld;
  assign ImmOp     = out_dat;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_vld & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_dat  <= '0;
      skid_dat <= '0;
    end else if (skid_vld) begin
      // in_ready is low here, so only the drain side can move.
      if (out_xfer) begin
        out_dat  <= skid_dat;
        skid_vld <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_vld || out_xfer) begin
        out_dat <= ext;
        out_vld <= 1'b1;
      end else begin
        skid_dat <= ext;
        skid_vld <= 1'b1;
      end
    end else if (out_xfer) begin
      out_vld <= 1'b0;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_src <= 1'b0;
    else if (in_xfer && ImmSrc == 3'b111)
      illegal_src <= 1'b1;
    else if (illegal_clr)
      illegal_src <= 1'b0;
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [24:0] instr_imm;
  logic [2:0]  ImmSrc;
  logic        out_ready;
  logic        illegal_clr;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .instr_imm(instr_imm), .ImmSrc(ImmSrc), .out_valid(out_valid32),
    .out_ready(out_ready), .ImmOp(imm32), .illegal_clr(illegal_clr),
    .illegal_src(illegal32)
  );

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .instr_imm(instr_imm), .ImmSrc(ImmSrc), .out_valid(out_valid64),
    .out_ready(out_ready), .ImmOp(imm64), .illegal_clr(illegal_clr),
    .illegal_src(illegal64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] e32;
    logic [63:0] e64;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_both(input string name, input logic [63:0] e32, input logic [63:0] e64);
    chk({name, "_vld32"}, {63'b0, out_valid32}, 64'd1);
    chk({name, "_vld64"}, {63'b0, out_valid64}, 64'd1);
    chk({name, "_imm32"}, {32'b0, imm32}, e32);
    chk({name, "_imm64"}, imm64, e64);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] src);
    logic [31:0] w;
    w         = instr;
    in_valid  = 1'b1;
    instr_imm = w[31:7];
    ImmSrc    = src;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF,         64'hFFFFFFFFFFFFFFFF};
    vt[1]  = '{32'h7FF00013, 3'b000, 64'h000007FF,         64'h00000000000007FF};
    vt[2]  = '{32'hFE112E23, 3'b001, 64'hFFFFFFFC,         64'hFFFFFFFFFFFFFFFC};
    vt[3]  = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFC,         64'hFFFFFFFFFFFFFFFC};
    vt[4]  = '{32'h12345037, 3'b011, 64'h00012345,         64'h0000000000012345};
    vt[5]  = '{32'h800000B7, 3'b011, 64'hFFF80000,         64'hFFFFFFFFFFF80000};
    vt[6]  = '{32'h008000EF, 3'b100, 64'h00000008,         64'h0000000000000008};
    vt[7]  = '{32'h123450B7, 3'b101, 64'h12345000,         64'h0000000012345000};
    vt[8]  = '{32'h800000B7, 3'b101, 64'h80000000,         64'hFFFFFFFF80000000};
    vt[9]  = '{32'h800F8073, 3'b110, 64'h0000001F,         64'h000000000000001F};
    vt[10] = '{32'h00000000, 3'b110, 64'h00000000,         64'h0000000000000000};
    vt[11] = '{32'hFFFFFFFF, 3'b111, 64'h00000000,         64'h0000000000000000};

    rst = 1'b1; in_valid = 1'b0; instr_imm = '0; ImmSrc = '0;
    out_ready = 1'b1; illegal_clr = 1'b0;
    #2;
    chk("rst_vld",   {62'b0, out_valid32, out_valid64}, 64'd0);
    chk("rst_rdy",   {62'b0, in_ready32, in_ready64},   64'd3);
    chk("rst_imm32", {32'b0, imm32},                    64'd0);
    chk("rst_imm64", imm64,                             64'd0);
    chk("rst_ill",   {62'b0, illegal32, illegal64},     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back table vectors with out_ready held high.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].instr, vt[i].src);
      tick();
      chk_both($sformatf("vec%0d", i), vt[i].e32, vt[i].e64);
    end
    in_valid = 1'b0;
    chk("ill_set", {62'b0, illegal32, illegal64}, 64'd3);
    tick();
    chk("drain_vld", {62'b0, out_valid32, out_valid64}, 64'd0);
    chk("ill_sticky", {62'b0, illegal32, illegal64}, 64'd3);
    illegal_clr = 1'b1;
    tick();
    illegal_clr = 1'b0;
    chk("ill_clr", {62'b0, illegal32, illegal64}, 64'd0);

    // Illegal select and clear in the same cycle: set wins.
    drive(32'h12345678, 3'b111);
    illegal_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_both("ill_race", 64'd0, 64'd0);
    chk("ill_race_flag", {62'b0, illegal32, illegal64}, 64'd3);
    tick();
    illegal_clr = 1'b0;
    chk("ill_clr2", {62'b0, illegal32, illegal64}, 64'd0);

    // Backpressure: fill OUT and SKID, then drain in order.
    out_ready = 1'b0;
    drive(32'h00100093, 3'b000);
    tick();
    chk("bp_rdy1", {62'b0, in_ready32, in_ready64}, 64'd3);
    drive(32'h00200093, 3'b000);
    tick();
    in_valid = 1'b0;
    chk("bp_rdy2", {62'b0, in_ready32, in_ready64}, 64'd0);
    chk_both("bp_hold1", 64'd1, 64'd1);
    drive(32'h00900093, 3'b000);
    tick();
    in_valid = 1'b0;
    chk_both("bp_hold2", 64'd1, 64'd1);
    chk("bp_rdy3", {62'b0, in_ready32, in_ready64}, 64'd0);
    out_ready = 1'b1;
    tick();
    chk_both("bp_out2", 64'd2, 64'd2);
    chk("bp_rdy4", {62'b0, in_ready32, in_ready64}, 64'd3);
    tick();
    chk("bp_empty", {62'b0, out_valid32, out_valid64}, 64'd0);

    // Sustained streaming: one result per cycle, in order.
    for (int k = 1; k <= 4; k++) begin
      drive({12'(k * 3), 20'h00093}, 3'b000);
      tick();
      chk_both($sformatf("stream%0d", k), 64'(k * 3), 64'(k * 3));
      chk($sformatf("stream_rdy%0d", k), {62'b0, in_ready32, in_ready64}, 64'd3);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", {62'b0, out_valid32, out_valid64}, 64'd0);

    // Reset mid-cycle with both entries full.
    out_ready = 1'b0;
    drive(32'h00500093, 3'b000);
    tick();
    drive(32'h00600093, 3'b000);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_rdy", {62'b0, in_ready32, in_ready64}, 64'd0);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_vld", {62'b0, out_valid32, out_valid64}, 64'd0);
    chk("mid_rst_rdy", {62'b0, in_ready32, in_ready64},   64'd3);
    chk("mid_rst_imm", imm64 | {32'b0, imm32},            64'd0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_vld", {62'b0, out_valid32, out_valid64}, 64'd0);
    drive(32'h00700093, 3'b000);
    tick();
    in_valid = 1'b0;
    chk_both("post_rst_first", 64'd7, 64'd7);
    chk("post_rst_rdy", {62'b0, in_ready32, in_ready64}, 64'd3);
    out_ready = 1'b1;
    tick();
    chk("post_rst_drain", {62'b0, out_valid32, out_valid64}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
